// File: rtl/snn_ctrl_pkg.sv
// Shared types and constants for the SNN inference controller and its rate encoder.
package snn_ctrl_pkg;

  localparam int SNN_PIXEL_BITS  = 8;
  localparam int SNN_NUM_CLASSES = 10;
  localparam int SNN_CNT_BITS    = 8;

  // One guard bit above the pixel width holds acc + pix before the wrap.
  localparam int ACC_W  = SNN_PIXEL_BITS + 1;
  localparam int ADDR_W = 8;
  localparam logic [ADDR_W-1:0] TICK_ADDR = '0;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SCAN,
    TICK,
    DRAIN,
    ARGMAX,
    DONE
  } state_t;

  typedef logic [SNN_CNT_BITS-1:0] cnt_arr_t [SNN_NUM_CLASSES];

endpackage

// File: rtl/snn_rate_encoder.sv
// Pixel buffer plus per-pixel phase accumulators; flags when the addressed pixel fires.
module snn_rate_encoder
  import snn_ctrl_pkg::*;
#(
  parameter int IMAGE_SIZE = 256,
  parameter int PIXEL_BITS = 8,
  parameter int IDX_W      = $clog2(IMAGE_SIZE)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 load,
  input  logic [IMAGE_SIZE-1:0][PIXEL_BITS-1:0] image,
  input  logic [IDX_W-1:0]                     idx,
  input  logic                                 commit,
  output logic                                 fire
);

  logic [PIXEL_BITS-1:0] pix [IMAGE_SIZE];
  logic [ACC_W-1:0]      acc [IMAGE_SIZE];
  logic [ACC_W-1:0]      sum;

  assign sum  = acc[idx] + {1'b0, pix[idx]};
  assign fire = sum[PIXEL_BITS];

  always_ff @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < IMAGE_SIZE; i++) pix[i] <= image[i];
    end
  end

  // A fired pixel keeps only the residue above one full period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < IMAGE_SIZE; i++) acc[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < IMAGE_SIZE; i++) acc[i] <= '0;
    end else if (commit) begin
      acc[idx] <= fire ? sum - ACC_W'(1 << PIXEL_BITS) : sum;
    end
  end

endmodule

// File: rtl/snn_inference_controller.sv
// Inference sequencer: rate-codes an image into AER events, counts class spikes, argmax.
// Optional early exit on a confident class is enabled by defining SNN_CTRL_EARLY_EXIT_EN.
module snn_inference_controller
  import snn_ctrl_pkg::*;
#(
  parameter int N                = 256,
  parameter int M                = $clog2(N),
  parameter int IMAGE_SIZE       = 256,
  parameter int IMAGE_SIZE_BITS  = $clog2(IMAGE_SIZE),
  parameter int PIXEL_MAX_VALUE  = 255,
  parameter int PIXEL_BITS       = $clog2(PIXEL_MAX_VALUE),
  parameter int NUM_TIMESTEPS    = 16,
  parameter int NUM_CLASSES      = SNN_NUM_CLASSES,
  parameter int CNT_BITS         = SNN_CNT_BITS,
  parameter int DRAIN_CYCLES     = 32,
  parameter int EARLY_EXIT_COUNT = 8
) (
  input  logic                                 CLK,
  input  logic                                 RST,
  input  logic [IMAGE_SIZE-1:0][PIXEL_BITS-1:0] IMAGE,
  input  logic                                 NEW_IMAGE,
  output logic [M-1:0]                         AER_ADDR,
  output logic                                 AER_TICK,
  output logic                                 AER_VALID,
  input  logic                                 AER_READY,
  input  logic                                 OUT_SPIKE,
  input  logic [3:0]                           OUT_ADDR,
  output logic [7:0]                           INFERED_DIGIT,
  output logic                                 COPROCESSOR_RDY,
  input  logic                                 RESULT_ACK,
  output logic                                 BUSY
);

  localparam int TS_W = $clog2(NUM_TIMESTEPS + 1);
  localparam int DR_W = $clog2(DRAIN_CYCLES);
  localparam int CL_W = $clog2(NUM_CLASSES);

`ifdef SNN_CTRL_EARLY_EXIT_EN
  localparam bit EARLY_EN = 1'b1;
`else
  localparam bit EARLY_EN = 1'b0;
`endif

  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
    return (&v) ? v : v + CNT_BITS'(1);
  endfunction

  state_t state, state_d;

  logic                       new_image_p1;
  logic                       new_rise;
  logic [IMAGE_SIZE_BITS-1:0] pix_idx, pix_idx_d;
  logic [TS_W-1:0]            ts_cnt, ts_d;
  logic [DR_W-1:0]            drain_cnt, drain_d;
  logic [CL_W-1:0]            arg_idx, arg_d, best_idx, best_idx_d;
  logic [CNT_BITS-1:0]        best_val, best_val_d;
  logic [M-1:0]               addr_d;
  logic                       valid_d, tick_d, rdy_d, busy_d;
  logic [7:0]                 digit_d;
  logic                       load, commit, fire;
  logic                       any_reached, early_hit, spike_ok;
  cnt_arr_t                   cnt;

  assign new_rise = NEW_IMAGE & ~new_image_p1;

  snn_rate_encoder #(
    .IMAGE_SIZE(IMAGE_SIZE),
    .PIXEL_BITS(PIXEL_BITS),
    .IDX_W     (IMAGE_SIZE_BITS)
  ) u_enc (
    .clk   (CLK),
    .rst   (RST),
    .load  (load),
    .image (IMAGE),
    .idx   (pix_idx),
    .commit(commit),
    .fire  (fire)
  );

  always_comb begin
    any_reached = 1'b0;
    for (int k = 0; k < NUM_CLASSES; k++) begin
      if (cnt[k] >= CNT_BITS'(EARLY_EXIT_COUNT)) any_reached = 1'b1;
    end
  end

  assign early_hit = EARLY_EN && any_reached;
  assign spike_ok  = OUT_SPIKE && (int'(OUT_ADDR) < NUM_CLASSES)
                     && (state inside {SCAN, TICK, DRAIN});

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d    = state;
    pix_idx_d  = pix_idx;
    ts_d       = ts_cnt;
    drain_d    = drain_cnt;
    arg_d      = arg_idx;
    best_idx_d = best_idx;
    best_val_d = best_val;
    valid_d    = AER_VALID;
    tick_d     = AER_TICK;
    addr_d     = AER_ADDR;
    digit_d    = INFERED_DIGIT;
    rdy_d      = COPROCESSOR_RDY;
    load       = 1'b0;
    commit     = 1'b0;
    unique case (state)
      IDLE: if (new_rise) state_d = LOAD;
      LOAD: begin
        load      = 1'b1;
        pix_idx_d = '0;
        ts_d      = '0;
        state_d   = SCAN;
      end
      SCAN: begin
        if (AER_VALID) begin
          if (AER_READY) begin
            commit  = 1'b1;
            valid_d = 1'b0;
            if (early_hit) begin
              state_d = DRAIN;
              drain_d = '0;
            end else if (pix_idx == IMAGE_SIZE_BITS'(IMAGE_SIZE - 1)) begin
              state_d = TICK;
              valid_d = 1'b1;
              tick_d  = 1'b1;
              addr_d  = M'(TICK_ADDR);
            end else begin
              pix_idx_d = pix_idx + IMAGE_SIZE_BITS'(1);
            end
          end
        end else if (early_hit) begin
          state_d = DRAIN;
          drain_d = '0;
        end else if (fire) begin
          valid_d = 1'b1;
          tick_d  = 1'b0;
          addr_d  = M'(pix_idx);
        end else begin
          commit = 1'b1;
          if (pix_idx == IMAGE_SIZE_BITS'(IMAGE_SIZE - 1)) begin
            state_d = TICK;
            valid_d = 1'b1;
            tick_d  = 1'b1;
            addr_d  = M'(TICK_ADDR);
          end else begin
            pix_idx_d = pix_idx + IMAGE_SIZE_BITS'(1);
          end
        end
      end
      TICK: begin
        if (AER_READY) begin
          ts_d    = ts_cnt + TS_W'(1);
          valid_d = 1'b0;
          tick_d  = 1'b0;
          if (early_hit || ts_cnt == TS_W'(NUM_TIMESTEPS - 1)) begin
            state_d = DRAIN;
            drain_d = '0;
          end else begin
            state_d   = SCAN;
            pix_idx_d = '0;
          end
        end
      end
      DRAIN: begin
        if (drain_cnt == DR_W'(DRAIN_CYCLES - 1)) begin
          state_d    = ARGMAX;
          arg_d      = '0;
          best_idx_d = '0;
          best_val_d = '0;
        end else begin
          drain_d = drain_cnt + DR_W'(1);
        end
      end
      ARGMAX: begin
        // Strict compare keeps the lowest index on ties.
        if (cnt[arg_idx] > best_val) begin
          best_val_d = cnt[arg_idx];
          best_idx_d = arg_idx;
        end
        if (arg_idx == CL_W'(NUM_CLASSES - 1)) begin
          state_d = DONE;
          rdy_d   = 1'b1;
          digit_d = 8'(best_idx_d);
        end else begin
          arg_d = arg_idx + CL_W'(1);
        end
      end
      DONE: begin
        if (new_rise) begin
          state_d = LOAD;
          rdy_d   = 1'b0;
        end else if (RESULT_ACK) begin
          state_d = IDLE;
          rdy_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d inside {LOAD, SCAN, TICK, DRAIN, ARGMAX};
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      new_image_p1    <= 1'b0;
      pix_idx         <= '0;
      ts_cnt          <= '0;
      drain_cnt       <= '0;
      arg_idx         <= '0;
      best_idx        <= '0;
      best_val        <= '0;
      AER_VALID       <= 1'b0;
      AER_TICK        <= 1'b0;
      AER_ADDR        <= '0;
      INFERED_DIGIT   <= '0;
      COPROCESSOR_RDY <= 1'b0;
      BUSY            <= 1'b0;
    end else begin
      new_image_p1    <= NEW_IMAGE;
      pix_idx         <= pix_idx_d;
      ts_cnt          <= ts_d;
      drain_cnt       <= drain_d;
      arg_idx         <= arg_d;
      best_idx        <= best_idx_d;
      best_val        <= best_val_d;
      AER_VALID       <= valid_d;
      AER_TICK        <= tick_d;
      AER_ADDR        <= addr_d;
      INFERED_DIGIT   <= digit_d;
      COPROCESSOR_RDY <= rdy_d;
      BUSY            <= busy_d;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int k = 0; k < NUM_CLASSES; k++) cnt[k] <= '0;
    end else if (state == LOAD) begin
      for (int k = 0; k < NUM_CLASSES; k++) cnt[k] <= '0;
    end else if (spike_ok) begin
      cnt[OUT_ADDR] <= sat_inc(cnt[OUT_ADDR]);
    end
  end

endmodule

// File: tb/tb_snn_inference_controller.sv
// Directed-plus-random bench for snn_inference_controller against a closed-form rate-code model.
module tb_snn_inference_controller;

  localparam int IS = 256;

  logic               CLK = 1'b0;
  logic               RST;
  logic [IS-1:0][7:0] IMAGE;
  logic               NEW_IMAGE, AER_READY, OUT_SPIKE, RESULT_ACK;
  logic [3:0]         OUT_ADDR;
  logic [7:0]         AER_ADDR, INFERED_DIGIT;
  logic               AER_TICK, AER_VALID, COPROCESSOR_RDY, BUSY;

  int tests = 0;
  int fails = 0;
  bit ready_rand = 1'b0;
  int stab_err = 0;
  int cap[$];
  int exp_ev[$];
  int spikes[$];
  int img[IS];

`ifdef SNN_CTRL_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  snn_inference_controller dut (
    .CLK            (CLK),
    .RST            (RST),
    .IMAGE          (IMAGE),
    .NEW_IMAGE      (NEW_IMAGE),
    .AER_ADDR       (AER_ADDR),
    .AER_TICK       (AER_TICK),
    .AER_VALID      (AER_VALID),
    .AER_READY      (AER_READY),
    .OUT_SPIKE      (OUT_SPIKE),
    .OUT_ADDR       (OUT_ADDR),
    .INFERED_DIGIT  (INFERED_DIGIT),
    .COPROCESSOR_RDY(COPROCESSOR_RDY),
    .RESULT_ACK     (RESULT_ACK),
    .BUSY           (BUSY)
  );

  always #5 CLK = ~CLK;

  initial begin
    AER_READY = 1'b1;
    forever begin
      @(posedge CLK);
      #1;
      AER_READY = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Event capture and handshake-stability watch, sampled mid-cycle.
  logic       pv = 1'b0, pr = 1'b0, pt = 1'b0;
  logic [7:0] pa = 8'd0;
  always @(negedge CLK) begin
    if (RST) begin
      pv = 1'b0;
    end else begin
      if (pv && !pr && (!AER_VALID || AER_ADDR !== pa || AER_TICK !== pt)) stab_err++;
      if (AER_VALID && AER_TICK && AER_ADDR !== 8'd0) stab_err++;
      if (AER_VALID && AER_READY) cap.push_back(AER_TICK ? -1 : int'(AER_ADDR));
      pv = AER_VALID;
      pr = AER_READY;
      pa = AER_ADDR;
      pt = AER_TICK;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Pixel p fires in timestep t exactly when floor(t*p/256) steps up.
  task automatic build_expect(output int n_pix);
    exp_ev.delete();
    n_pix = 0;
    for (int t = 1; t <= 16; t++) begin
      for (int i = 0; i < IS; i++) begin
        if ((t * img[i]) / 256 != ((t - 1) * img[i]) / 256) begin
          exp_ev.push_back(i);
          n_pix++;
        end
      end
      exp_ev.push_back(-1);
    end
  endtask

  function automatic int exp_digit();
    int c[16];
    int best;
    best = 0;
    for (int k = 0; k < 16; k++) c[k] = 0;
    foreach (spikes[j]) if (spikes[j] < 10 && c[spikes[j]] < 255) c[spikes[j]]++;
    for (int k = 1; k < 10; k++) if (c[k] > c[best]) best = k;
    return best;
  endfunction

  function automatic int count_addr(input int a);
    int n;
    n = 0;
    foreach (cap[k]) if (cap[k] == a) n++;
    return n;
  endfunction

  task automatic run(input string name, input bit rnd, input bit chk_seq, input bit chk_lat,
                     input bit toggle, input bit ack, output int cyc);
    int  n_pix, lat_exp, dig;
    int  q[$];
    bit  seq_ok;
    build_expect(n_pix);
    dig     = exp_digit();
    q       = spikes;
    lat_exp = 16 * 257 + n_pix + 32 + 10 + 2;
    for (int i = 0; i < IS; i++) IMAGE[i] = 8'(img[i]);
    cap.delete();
    ready_rand = rnd;
    @(posedge CLK);
    #1;
    NEW_IMAGE = 1'b1;
    cyc = 0;
    do begin
      @(posedge CLK);
      #1;
      cyc++;
      if (cyc == 1) begin
        chk({name, ".busy_start"}, 32'(BUSY), 1);
        chk({name, ".rdy_start"}, 32'(COPROCESSOR_RDY), 0);
      end
      if (toggle && cyc == 100) NEW_IMAGE = 1'b0;
      if (toggle && cyc == 200) NEW_IMAGE = 1'b1;
      if (cyc >= 5 && q.size() > 0) begin
        OUT_SPIKE = 1'b1;
        OUT_ADDR  = 4'(q.pop_front());
      end else begin
        OUT_SPIKE = 1'b0;
      end
    end while (!COPROCESSOR_RDY && cyc < 20000);
    OUT_SPIKE  = 1'b0;
    ready_rand = 1'b0;
    chk({name, ".no_timeout"}, 32'(cyc < 20000), 1);
    chk({name, ".digit"}, 32'(INFERED_DIGIT), dig);
    chk({name, ".busy_done"}, 32'(BUSY), 0);
    chk({name, ".aer_stable"}, stab_err, 0);
    if (chk_lat) chk({name, ".latency"}, cyc, lat_exp);
    if (chk_seq) begin
      chk({name, ".n_events"}, cap.size(), exp_ev.size());
      seq_ok = (cap.size() == exp_ev.size());
      if (seq_ok) foreach (cap[k]) if (cap[k] != exp_ev[k]) seq_ok = 1'b0;
      chk({name, ".event_seq"}, 32'(seq_ok), 1);
    end
    NEW_IMAGE = 1'b0;
    @(posedge CLK);
    #1;
    chk({name, ".rdy_hold"}, 32'(COPROCESSOR_RDY), 1);
    chk({name, ".digit_hold"}, 32'(INFERED_DIGIT), dig);
    if (ack) begin
      RESULT_ACK = 1'b1;
      @(posedge CLK);
      #1;
      RESULT_ACK = 1'b0;
      chk({name, ".ack_rdy"}, 32'(COPROCESSOR_RDY), 0);
      chk({name, ".ack_busy"}, 32'(BUSY), 0);
    end
  endtask

  task automatic rand_image();
    for (int i = 0; i < IS; i++)
      img[i] = ($urandom_range(0, 9) < 3) ? int'($urandom_range(1, 255)) : 0;
  endtask

  task automatic rand_spikes();
    spikes.delete();
    for (int k = 0; k < 10; k++) begin
      int n;
      n = int'($urandom_range(0, 7));
      for (int j = 0; j < n; j++) spikes.push_back(k);
    end
    for (int j = 0; j < 6; j++) spikes.push_back(int'($urandom_range(10, 15)));
  endtask

  initial begin
    int  lat;
    bit  found;
    RST        = 1'b1;
    NEW_IMAGE  = 1'b0;
    OUT_SPIKE  = 1'b0;
    OUT_ADDR   = 4'd0;
    RESULT_ACK = 1'b0;
    IMAGE      = '0;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    @(posedge CLK);
    #1;
    chk("reset.valid", 32'(AER_VALID), 0);
    chk("reset.tick", 32'(AER_TICK), 0);
    chk("reset.addr", 32'(AER_ADDR), 0);
    chk("reset.digit", 32'(INFERED_DIGIT), 0);
    chk("reset.rdy", 32'(COPROCESSOR_RDY), 0);
    chk("reset.busy", 32'(BUSY), 0);

    foreach (img[i]) img[i] = 0;
    spikes.delete();
    run("zero", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, lat);
    chk("zero.latency_4156", lat, 4156);
    chk("zero.ticks", count_addr(-1), 16);

    img[5] = 128;
    spikes = {3, 3, 3, 3, 3, 7, 7, 11, 11, 11, 11, 11, 11, 11, 11, 11};
    run("pix5", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, lat);
    chk("pix5.addr5_events", count_addr(5), 8);

    img[5]   = 0;
    img[255] = 255;
    spikes   = {4, 4, 4, 6, 6, 6};
    run("pix255", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, lat);
    chk("pix255.events", count_addr(255), 15);
    chk("pix255.first_is_tick", (cap.size() > 0) ? cap[0] : 0, -1);

    rand_image();
    rand_spikes();
    run("rand_ready", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, lat);

    foreach (img[i]) img[i] = 0;
    spikes.delete();
    for (int j = 0; j < 300; j++) spikes.push_back(2);
    for (int j = 0; j < 100; j++) spikes.push_back(5);
    run("sat", 1'b0, !EE, !EE, 1'b0, 1'b0, lat);

    rand_image();
    rand_spikes();
    run("from_done", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, lat);

`ifdef SNN_CTRL_EARLY_EXIT_EN
    foreach (img[i]) img[i] = 0;
    spikes = {1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
    run("early", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, lat);
    chk("early.short_latency", 32'(lat < 200), 1);
`endif

    foreach (img[i]) img[i] = 255;
    for (int i = 0; i < IS; i++) IMAGE[i] = 8'd255;
    @(posedge CLK);
    #1;
    NEW_IMAGE = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 2000 && !found; c++) begin
      @(posedge CLK);
      #1;
      if (AER_VALID && !AER_TICK) found = 1'b1;
    end
    chk("rst_mid.found_event", 32'(found), 1);
    RST = 1'b1;
    #1;
    chk("rst_mid.valid", 32'(AER_VALID), 0);
    chk("rst_mid.tick", 32'(AER_TICK), 0);
    chk("rst_mid.addr", 32'(AER_ADDR), 0);
    chk("rst_mid.digit", 32'(INFERED_DIGIT), 0);
    chk("rst_mid.rdy", 32'(COPROCESSOR_RDY), 0);
    chk("rst_mid.busy", 32'(BUSY), 0);
    @(posedge CLK);
    #1;
    RST       = 1'b0;
    NEW_IMAGE = 1'b0;
    @(posedge CLK);
    #1;
    rand_image();
    rand_spikes();
    run("after_rst", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, lat);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/snn_inference_controller.md
# snn_inference_controller

Sequencer between the AXI4-Lite slave interface and the SNN core. When a new image is flagged, it latches the pixel array and rate-codes it into AER input events over NUM_TIMESTEPS timesteps, with a tick event at the end of each timestep. It counts the core's output-neuron spikes per class and resolves the winning class by argmax. It presents INFERED_DIGIT / COPROCESSOR_RDY back to the interface until acknowledged.

## Interface
- N, 256, number of input neurons
- M, $clog2(N), neuron address width
- IMAGE_SIZE, 256, pixels per image
- IMAGE_SIZE_BITS, $clog2(IMAGE_SIZE), pixel index width
- PIXEL_MAX_VALUE, 255, maximum pixel value
- PIXEL_BITS, $clog2(PIXEL_MAX_VALUE), pixel width (8)
- NUM_TIMESTEPS, 16, timesteps per inference
- NUM_CLASSES, 10, output neurons / classes
- CNT_BITS, 8, per-class spike counter width
- DRAIN_CYCLES, 32, wait after the last tick for late output spikes
- EARLY_EXIT_COUNT, 8, early-exit threshold (see Configuration)

Ports:
- CLK  in  1  clock; the single clock domain
- RST  in  1  asynchronous, active-high reset
- IMAGE  in  [PIXEL_BITS-1:0] x IMAGE_SIZE  pixel array from the AXI interface
- NEW_IMAGE  in  1  level from the AXI interface; its rising edge starts an inference
- AER_ADDR  out  M  input-neuron address (pixel index), or 0 for a tick
- AER_TICK  out  1  event is a timestep-end tick
- AER_VALID  out  1  event valid
- AER_READY  in  1  core accepts the event
- OUT_SPIKE  in  1  one-cycle output-neuron spike
- OUT_ADDR  in  4  class index of the spike
- INFERED_DIGIT  out  8  winning class
- COPROCESSOR_RDY  out  1  result valid
- RESULT_ACK  in  1  result consumed
- BUSY  out  1  inference in progress

## Operation
- States: IDLE, LOAD, SCAN, TICK, DRAIN, ARGMAX, DONE.
- IDLE → LOAD on a rising edge of NEW_IMAGE (edge detected with a registered copy of the level).
- LOAD, one cycle:
  - Copy IMAGE into an internal buffer.
  - Clear the per-pixel accumulators acc[i] (PIXEL_BITS+1 bits).
  - Clear the class counters.
  - Reset pixel index and timestep counter to 0.
- SCAN: per pixel i, compute sum = acc[i] + pix[i].
  - If sum < 2^PIXEL_BITS: acc[i] ← sum, advance i, one cycle, no event.
  - Otherwise: drive AER_VALID=1, AER_ADDR=i, AER_TICK=0 and hold until AER_READY. On the handshake, acc[i] ← sum − 2^PIXEL_BITS and advance i.
  - After i = IMAGE_SIZE−1 → TICK.
- TICK: AER_VALID=1, AER_TICK=1, AER_ADDR=0, held until AER_READY.
  - On the handshake the timestep counter increments.
  - If the count is < NUM_TIMESTEPS → SCAN with i=0; otherwise → DRAIN.
- DRAIN: wait DRAIN_CYCLES cycles, then → ARGMAX.
- ARGMAX: sequential scan of classes 0..NUM_CLASSES−1, one per cycle.
  - Strict greater-than comparison, so ties resolve to the lowest index; all-zero counters give 0.
  - At the end → DONE.
- DONE: COPROCESSOR_RDY=1 and INFERED_DIGIT held stable.
  - RESULT_ACK → IDLE and RDY drops.
  - A NEW_IMAGE rising edge in DONE behaves as ACK followed by start: → LOAD.
- Spike counting: OUT_SPIKE increments counter[OUT_ADDR] in SCAN, TICK and DRAIN only.
  - Counters saturate at 2^CNT_BITS−1.
  - OUT_ADDR ≥ NUM_CLASSES is ignored.
  - Spikes in all other states are ignored.
- NEW_IMAGE edges while BUSY are ignored.
- BUSY = 1 in LOAD through ARGMAX.

## Timing
- Reset values: AER_VALID=0, AER_TICK=0, AER_ADDR=0, INFERED_DIGIT=0, COPROCESSOR_RDY=0, BUSY=0; state IDLE; accumulators and counters 0.
- RST mid-operation aborts immediately to the reset values; an AER event in flight is dropped.
- All outputs are registered.
- AER handshake: once AER_VALID is raised, AER_ADDR and AER_TICK are stable until the cycle AER_READY=1 is sampled with VALID. The next event can be valid in the following cycle.
- With AER_READY tied high:
  - latency ≈ NUM_TIMESTEPS·(IMAGE_SIZE+1) + spikes + DRAIN_CYCLES + NUM_CLASSES + 2 cycles;
  - an all-zero image takes 16·257 + 32 + 10 + 2 = 4156 cycles from NEW_IMAGE edge to RDY.
- COPROCESSOR_RDY rises one cycle after the last ARGMAX cycle.

## Configuration
- SNN_CTRL_EARLY_EXIT_EN defined:
  - In SCAN or TICK, when any class counter reaches EARLY_EXIT_COUNT, the controller finishes the current AER handshake (if one is pending) and then goes to DRAIN.
  - Remaining timesteps are skipped.
- SNN_CTRL_EARLY_EXIT_EN undefined: all NUM_TIMESTEPS always run, and the EARLY_EXIT_COUNT parameter is unused.

## Structure
- Shared package snn_ctrl_pkg holds:
  - the state enum typedef;
  - localparams for the accumulator width and the tick address;
  - the class-counter array typedef.
- One sub-module is natural: snn_rate_encoder, containing the pixel buffer, the accumulators and the per-pixel spike decision. The FSM, counters and argmax stay in the top.

## Test plan
- All-zero image, AER_READY=1 → exactly 16 tick events and no pixel events; INFERED_DIGIT=0 and RDY at cycle 4156.
- Pixel 5 = 128, all others 0 → 8 events with AER_ADDR=5, in timesteps 2, 4, …, 16; pixel 255 alone → 15 events, none in timestep 1.
- AER_READY toggled randomly at 50% → the same event sequence as with READY=1, and ADDR/TICK stable while VALID and not READY.
- Inject OUT_SPIKE for class 3 ×5, class 7 ×2, class 11 ×9 → INFERED_DIGIT=3; equal counts for classes 4 and 6 → 4.
- 300 spikes on class 2 → counter saturates at 255 with no wrap, digit 2; with SNN_CTRL_EARLY_EXIT_EN, 8 spikes on class 1 by timestep 3 → DRAIN entered early and digit 1.
- RST asserted mid-SCAN with AER_VALID=1 → all outputs at reset values next cycle; a new NEW_IMAGE edge then completes a normal inference, and RESULT_ACK clears RDY.
